rr_hold_arbiter: RTL and testbench
==================================

# rr_hold_arbiter

Arbitrates a shared resource (bus or memory port) between N requesters using round-robin fairness. Each grant is held until the owner signals `done`, withdraws its request, or exceeds a maximum hold time. It sits in front of the shared datapath and replaces fixed per-cycle arbitration wherever a requester needs multi-cycle ownership. Grants are registered one-hot. Every release is followed by exactly one dead cycle before the next grant.

## Interface
- `N`, default 4: number of requesters, 2..16.
- `HOLD_MAX`, default 16: maximum cycles a grant is held, 1..255.
- `IDW`, default `$clog2(N)`: width of `gnt_id`.
- `CW`, default 8: width of the hold counter.

Ports (name, direction, width, meaning):
- `clk`, in, 1: single clock; all logic is rising-edge.
- `rstn`, in, 1: reset, asynchronous, active-low.
- `req`, in, N: request per requester; level, held while the requester wants ownership.
- `done`, in, N: release per requester; only `done[gnt_id]` is honoured while busy.
- `gnt`, out, N: registered one-hot grant, or all zero.
- `gnt_id`, out, IDW: index of the current or most recent grant.
- `busy`, out, 1: high while any `gnt` bit is set.
- `timeout`, out, 1: one-cycle pulse when a grant is revoked by the hold limit.

## Operation
- Reset values: `gnt`=0, `gnt_id`=0, `busy`=0, `timeout`=0, `ptr`=0, `cnt`=0, state=IDLE.
- State machine:
  - IDLE, when `req`≠0: select the first set `req[i]` searching from `i=ptr` upward, modulo N. Set `gnt[i]`=1, `gnt_id`=i, `cnt`=1, move to GRANT.
  - IDLE, when `req`=0: remain in IDLE with outputs zero.
  - GRANT, release when any of these holds at a clock edge:
    - `done[gnt_id]`=1;
    - `req[gnt_id]`=0;
    - `cnt`==HOLD_MAX.
  - On release: `gnt`=0, `ptr`=(`gnt_id`+1) mod N, return to IDLE. `gnt_id` retains its value.
  - GRANT, no release: `cnt` increments by 1.
- `timeout`=1 for the single cycle after a release caused only by the hold limit.
  - If `done` or request withdrawal coincides with `cnt`==HOLD_MAX, it is a normal release and no timeout is signalled.
- `done` or `req` changes from non-owners during GRANT are ignored; no preemption.
- `ptr` wraps from N-1 to 0.
- A requester that is still requesting after its release is reconsidered only after all others at and after `ptr`.
- `busy` = (state==GRANT), registered with `gnt`.
- `cnt` width CW must hold HOLD_MAX; there is no overflow, because the hold limit releases first.

## Timing
- Request-to-grant latency:
  - `req` sampled high in IDLE at edge k gives `gnt` high after edge k.
  - Minimum latency is 1 cycle.
- Grant duration is 1..HOLD_MAX cycles; `gnt` is high for exactly HOLD_MAX cycles on timeout.
- Release sampled at edge k drops `gnt` after edge k. The earliest next grant is after edge k+1 (one dead cycle).
- `timeout` is high during the first dead cycle only.
- Asserting `rstn` low mid-grant clears `gnt`, `busy` and `timeout` immediately, without waiting for a clock. After deassertion, arbitration restarts from `ptr`=0.
- Zero combinational paths from inputs to outputs.

## Test plan
- Reset check: N=4, `rstn` low while `req`=4'b1111.
  - Response: all outputs 0.
  - Release `rstn`: `gnt`=4'b0001 after the first edge, `gnt_id`=0.
- Round-robin fairness: `req`=4'b1111 held, each owner pulses `done` 2 cycles into its grant.
  - Response: grant order 0,1,2,3,0.
  - Each grant lasts 2 cycles, with 1 dead cycle between grants.
- Hold limit: HOLD_MAX=16, `req[2]` held alone, `done`=0.
  - Response: `gnt`=4'b0100 for exactly 16 cycles, then `timeout` pulses 1 cycle.
  - Regrant to 2 one cycle later; `ptr` has moved to 3 but no other requester is pending.
- Withdrawal and foreign `done`:
  - Owner 1 drops `req[1]` on grant cycle 3: release, no `timeout`.
  - `done[3]` asserted while 1 is owner: ignored, grant continues.
- Coincident events: `done[gnt_id]` asserted on the cycle `cnt`==HOLD_MAX → release with `timeout`=0.
- Wrap and reset mid-grant:
  - Last grant was 3 and `req`=4'b1001 → next grant is 0.
  - `rstn` pulsed low during grant to 0 → `gnt`=0 asynchronously; after reset the first grant is 0 again (`ptr`=0).

Source files
------------

// File: rtl/rr_hold_arbiter.sv
// Round-robin arbiter with held grants; registered one-hot grant 1 cycle after request, one dead cycle after every release.
// No backpressure: a grant lasts until owner done, owner request drop, or HOLD_MAX cycles.
module rr_hold_arbiter #(
    parameter int N        = 4,
    parameter int HOLD_MAX = 16,
    parameter int IDW      = $clog2(N),
    parameter int CW       = 8
) (
    input  logic           clk,
    input  logic           rstn,
    input  logic [N-1:0]   req,
    input  logic [N-1:0]   done,
    output logic [N-1:0]   gnt,
    output logic [IDW-1:0] gnt_id,
    output logic           busy,
    output logic           timeout
);

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    localparam logic [IDW:0]   N_W      = (IDW+1)'(N);
    localparam logic [IDW-1:0] LAST_ID  = IDW'(N - 1);
    localparam logic [CW-1:0]  HOLD_LIM = CW'(HOLD_MAX);
    localparam logic [N-1:0]   ONE_HOT0 = N'(1);

    state_t         state;
    logic [IDW-1:0] ptr;
    logic [CW-1:0]  cnt;

    // Rotate requests so bit 0 is the requester at ptr, then take the lowest set bit.
    logic [2*N-1:0] req_dbl;
    logic [N-1:0]   req_rot;
    logic           found;
    logic [IDW-1:0] offset;
    logic [IDW:0]   pick_sum;
    logic [IDW-1:0] pick;

    assign req_dbl = {req, req};
    assign req_rot = N'(req_dbl >> ptr);

    always_comb begin
        found  = 1'b0;
        offset = '0;
        for (int k = N - 1; k >= 0; k--) begin
            if (req_rot[k]) begin
                found  = 1'b1;
                offset = IDW'(k);
            end
        end
    end

    assign pick_sum = {1'b0, ptr} + {1'b0, offset};
    assign pick     = (pick_sum >= N_W) ? IDW'(pick_sum - N_W) : pick_sum[IDW-1:0];

    logic           own_done;
    logic           own_drop;
    logic           at_limit;
    logic           release_now;
    logic [IDW-1:0] ptr_after;

    assign own_done    = done[gnt_id];
    assign own_drop    = ~req[gnt_id];
    assign at_limit    = (cnt == HOLD_LIM);
    assign release_now = own_done | own_drop | at_limit;
    assign ptr_after   = (gnt_id == LAST_ID) ? '0 : gnt_id + IDW'(1);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state   <= IDLE;
            gnt     <= '0;
            gnt_id  <= '0;
            busy    <= 1'b0;
            timeout <= 1'b0;
            ptr     <= '0;
            cnt     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    timeout <= 1'b0;
                    if (found) begin
                        state  <= GRANT;
                        gnt    <= ONE_HOT0 << pick;
                        gnt_id <= pick;
                        busy   <= 1'b1;
                        cnt    <= CW'(1);
                    end
                end
                GRANT: begin
                    if (release_now) begin
                        state   <= IDLE;
                        gnt     <= '0;
                        busy    <= 1'b0;
                        ptr     <= ptr_after;
                        // Only a pure hold-limit release is reported as a timeout.
                        timeout <= at_limit & ~own_done & ~own_drop;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                default: begin
                    state <= IDLE;
                    gnt   <= '0;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

    a_gnt_onehot: assert property (@(posedge clk) disable iff (!rstn) $onehot0(gnt));
    a_busy_gnt:   assert property (@(posedge clk) disable iff (!rstn) busy == (gnt != '0));

endmodule

// File: tb/tb_rr_hold_arbiter.sv
// Bench for rr_hold_arbiter: per-cycle expected outputs from a grant-level model are queued and checked by a monitor.
module tb_rr_hold_arbiter;

    localparam int N   = 4;
    localparam int HM  = 16;
    localparam int IDW = 2;
    localparam int CW  = 8;

    logic           clk  = 1'b0;
    logic           rstn = 1'b0;
    logic [N-1:0]   req  = '0;
    logic [N-1:0]   done = '0;
    logic [N-1:0]   gnt;
    logic [IDW-1:0] gnt_id;
    logic           busy;
    logic           timeout;

    always #5 clk = ~clk;

    rr_hold_arbiter #(.N(N), .HOLD_MAX(HM), .IDW(IDW), .CW(CW)) dut (
        .clk     (clk),
        .rstn    (rstn),
        .req     (req),
        .done    (done),
        .gnt     (gnt),
        .gnt_id  (gnt_id),
        .busy    (busy),
        .timeout (timeout)
    );

    typedef struct packed {
        logic [N-1:0]   gnt;
        logic [IDW-1:0] id;
        logic           busy;
        logic           tmo;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   tests = 0;
    int   fails = 0;

    // Reference model: who owns the resource, for how long, and where the search starts.
    int m_owner = -1;
    int m_cnt   = 0;
    int m_ptr   = 0;
    int m_id    = 0;
    bit m_tmo   = 1'b0;

    function automatic logic [N-1:0] oh(input int i);
        logic [N-1:0] v;
        v = '0;
        v[i[IDW-1:0]] = 1'b1;
        return v;
    endfunction

    function automatic exp_t m_expect();
        exp_t e;
        e.gnt  = (m_owner >= 0) ? oh(m_owner) : '0;
        e.id   = IDW'(m_id);
        e.busy = (m_owner >= 0);
        e.tmo  = m_tmo;
        return e;
    endfunction

    task automatic m_reset();
        m_owner = -1;
        m_cnt   = 0;
        m_ptr   = 0;
        m_id    = 0;
        m_tmo   = 1'b0;
    endtask

    task automatic m_step(input logic [N-1:0] r, input logic [N-1:0] d);
        int c;
        bit rd, rw, rl;
        if (m_owner < 0) begin
            m_tmo = 1'b0;
            for (int k = 0; k < N; k++) begin
                c = (m_ptr + k) % N;
                if (r[c[IDW-1:0]]) begin
                    m_owner = c;
                    m_id    = c;
                    m_cnt   = 1;
                    break;
                end
            end
        end else begin
            rd = d[m_owner[IDW-1:0]];
            rw = !r[m_owner[IDW-1:0]];
            rl = (m_cnt == HM);
            if (rd || rw || rl) begin
                m_tmo   = rl && !rd && !rw;
                m_ptr   = (m_owner + 1) % N;
                m_owner = -1;
            end else begin
                m_cnt++;
            end
        end
    endtask

    // Drive one cycle of inputs; an asynchronous reset also zeroes the expectation for the current cycle.
    task automatic tick(input logic [N-1:0] r, input logic [N-1:0] d, input logic rs);
        req  = r;
        done = d;
        rstn = rs;
        if (!rs) begin
            m_reset();
            if (sb.size() > 0) sb[sb.size()-1] = '0;
        end
        @(posedge clk);
        if (rstn) m_step(req, done);
        else      m_reset();
        sb.push_back(m_expect());
        #2;
    endtask

    int           order_log[$];
    int           run_len  = 0;
    int           tmo_seen = 0;
    logic [N-1:0] prev_gnt = '0;

    initial begin
        forever begin
            @(negedge clk);
            if (sb.size() > 0) begin
                mon_e = sb.pop_front();
                tests++;
                if ({gnt, gnt_id, busy, timeout} !== mon_e) begin
                    fails++;
                    $display("FAIL outputs t=%0t: got gnt=%b id=%0d busy=%b tmo=%b, want gnt=%b id=%0d busy=%b tmo=%b",
                             $time, gnt, gnt_id, busy, timeout, mon_e.gnt, mon_e.id, mon_e.busy, mon_e.tmo);
                end
            end
            if (gnt != '0 && prev_gnt == '0) begin
                order_log.push_back(int'(gnt_id));
                run_len = 1;
            end else if (gnt != '0) begin
                run_len++;
            end
            if (timeout) begin
                tmo_seen++;
                tests++;
                if (run_len != HM) begin
                    fails++;
                    $display("FAIL hold_len: grant lasted %0d cycles before timeout, want %0d", run_len, HM);
                end
            end
            prev_gnt = gnt;
        end
    end

    task automatic check_order(input string name, input int exp_q[$]);
        bit ok;
        ok = (order_log.size() == exp_q.size());
        for (int i = 0; i < exp_q.size() && ok; i++)
            if (order_log[i] != exp_q[i]) ok = 1'b0;
        tests++;
        if (!ok) begin
            fails++;
            $display("FAIL %s: got grant order %p, want %p", name, order_log, exp_q);
        end
    endtask

    task automatic settle();
        @(negedge clk);
        #1;
    endtask

    int           tmo_before;
    logic [N-1:0] cur_req;
    logic [N-1:0] rnd_done;
    logic         rnd_rst;

    initial begin
        // Reset held with all requesters asking.
        tick(4'hF, 4'h0, 1'b0);
        tick(4'hF, 4'h0, 1'b0);

        // Fairness: every owner signals done on its second grant cycle.
        order_log.delete();
        for (int i = 0; i < 15; i++)
            tick(4'hF, (m_owner >= 0 && m_cnt == 2) ? oh(m_owner) : '0, 1'b1);
        settle();
        check_order("rr_order", '{0, 1, 2, 3, 0});

        // Hold limit with a lone requester.
        tick(4'h0, 4'h0, 1'b1);
        tick(4'h0, 4'h0, 1'b1);
        tmo_before = tmo_seen;
        order_log.delete();
        for (int i = 0; i < 40; i++)
            tick(4'b0100, 4'h0, 1'b1);
        settle();
        tests++;
        if (tmo_seen - tmo_before != 2) begin
            fails++;
            $display("FAIL hold_timeouts: got %0d timeout pulses, want 2", tmo_seen - tmo_before);
        end
        check_order("hold_regrant", '{2, 2, 2});

        // done from the owner lands exactly on the hold limit: normal release.
        tick(4'h0, 4'h0, 1'b1);
        tick(4'h0, 4'h0, 1'b1);
        tmo_before = tmo_seen;
        for (int i = 0; i < 20; i++)
            tick(4'b0100, (m_owner == 2 && m_cnt == HM) ? 4'b0100 : 4'b0000, 1'b1);
        settle();
        tests++;
        if (tmo_seen != tmo_before) begin
            fails++;
            $display("FAIL coincident: got %0d timeout pulses, want 0", tmo_seen - tmo_before);
        end

        // Owner 1 withdraws on grant cycle 3; a foreign done[3] is ignored.
        tick(4'h0, 4'h0, 1'b1);
        tick(4'h0, 4'h0, 1'b1);
        for (int i = 0; i < 12; i++)
            tick((m_owner == 1 && m_cnt == 3) ? 4'b0000 : 4'b0010,
                 (m_owner == 1 && m_cnt == 2) ? 4'b1000 : 4'b0000, 1'b1);

        // Wrap from 3 to 0, then reset in the middle of the grant to 0.
        tick(4'h0, 4'h0, 1'b1);
        tick(4'h0, 4'h0, 1'b1);
        order_log.delete();
        tick(4'b1000, 4'h0, 1'b1);
        tick(4'b1000, 4'h0, 1'b1);
        tick(4'b1001, 4'b1000, 1'b1);
        tick(4'b1001, 4'h0, 1'b1);
        tick(4'b1001, 4'h0, 1'b1);
        tick(4'b1001, 4'h0, 1'b0);
        tick(4'b1111, 4'h0, 1'b0);
        tick(4'b1111, 4'h0, 1'b1);
        tick(4'b1111, 4'h0, 1'b1);
        settle();
        check_order("wrap_reset", '{3, 0, 0});

        // Random traffic with occasional resets.
        cur_req = '0;
        for (int i = 0; i < 2000; i++) begin
            if ($urandom_range(0, 7) == 0) cur_req = cur_req ^ oh($urandom_range(0, N - 1));
            rnd_done = ($urandom_range(0, 5) == 0) ? N'($urandom) : '0;
            rnd_rst  = ($urandom_range(0, 299) == 0) ? 1'b0 : 1'b1;
            tick(cur_req, rnd_done, rnd_rst);
        end
        tick(4'h0, 4'h0, 1'b1);
        settle();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
